// File: rtl/dtack_wait_controller.sv
// dtack_wait_controller
// Sequences a 68000 bus cycle: samples AS in IDLE, grants the lowest-index
// active chip-select, counts that requester's wait states, hands the cycle to
// the stepper via STEP_REQ/STEP_ACK_IN and raises DTACK on acknowledge.
// All state and outputs update on the falling edge of MCLK_IN.
// Optional feature macro: BERR_TIMEOUT_EN (unmapped strobe -> BERR after TIMEOUT).
module dtack_wait_controller #(
  parameter int                          NREQ      = 4,
  parameter int                          WAIT_BITS = 4,
  parameter logic [NREQ*WAIT_BITS-1:0]   WAIT_CFG  = {NREQ*WAIT_BITS{1'b0}},
  parameter logic [7:0]                  TIMEOUT   = 8'd255
) (
  input  logic            MCLK_IN,
  input  logic            RUN_IN,
  input  logic            AS_IN,
  input  logic [NREQ-1:0] CS_IN,
  input  logic            STEP_ACK_IN,
  output logic            STEP_REQ,
  output logic            DTACK,
  output logic            BERR,
  output logic [NREQ-1:0] GRANT,
  output logic            BUSY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [WAIT_BITS-1:0] CNT_ONE = WAIT_BITS'(1);

  logic [2:0]           r_state, w_state_n;
  logic [WAIT_BITS-1:0] r_cnt, w_cnt_n;
  logic                 r_req, w_req_n;
  logic                 r_dtack, w_dtack_n;
  logic                 r_berr, w_berr_n;
  logic                 r_busy;
  logic [NREQ-1:0]      r_grant, w_grant_n;
  logic [NREQ-1:0]      w_pick;
  logic [WAIT_BITS-1:0] w_pick_wait;
`ifdef BERR_TIMEOUT_EN
  logic [7:0]           r_tocnt, w_tocnt_n;
`endif

  // Fixed-priority pick: the lowest set chip-select wins, along with its wait count
  always_comb begin
    w_pick      = '0;
    w_pick_wait = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (CS_IN[i]) begin
        w_pick      = '0;
        w_pick[i]   = 1'b1;
        w_pick_wait = WAIT_CFG[i*WAIT_BITS +: WAIT_BITS];
      end else begin
        w_pick      = w_pick;
        w_pick_wait = w_pick_wait;
      end
    end
  end

  // Next-state and next-output computation for the bus-cycle sequencer
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_req_n   = r_req;
    w_dtack_n = r_dtack;
    w_berr_n  = r_berr;
    w_grant_n = r_grant;
`ifdef BERR_TIMEOUT_EN
    w_tocnt_n = 8'd0;
`endif
    case (r_state)
      S_IDLE: begin
        if (AS_IN && (CS_IN != '0)) begin
          w_grant_n = w_pick;
          w_cnt_n   = w_pick_wait;
          if (w_pick_wait == '0) begin
            w_state_n = S_STEP;
            w_req_n   = 1'b1;
          end else begin
            w_state_n = S_WAIT;
          end
        end else begin
`ifdef BERR_TIMEOUT_EN
          // Unmapped strobe: count edges until the tolerance runs out
          if (AS_IN && (r_tocnt == (TIMEOUT - 8'd1))) begin
            w_state_n = S_ERROR;
            w_berr_n  = 1'b1;
          end else if (AS_IN) begin
            w_tocnt_n = r_tocnt + 8'd1;
          end else begin
            w_tocnt_n = 8'd0;
          end
`else
          // Unmapped strobe is simply ignored until AS drops
          w_state_n = S_IDLE;
`endif
        end
      end
      S_WAIT: begin
        if (!AS_IN) begin
          w_state_n = S_IDLE;
          w_req_n   = 1'b0;
          w_grant_n = '0;
          w_cnt_n   = '0;
        end else if (r_cnt == CNT_ONE) begin
          w_state_n = S_STEP;
          w_req_n   = 1'b1;
        end else begin
          w_cnt_n   = r_cnt - CNT_ONE;
        end
      end
      S_STEP: begin
        // An AS drop wins over a coincident acknowledge
        if (!AS_IN) begin
          w_state_n = S_IDLE;
          w_req_n   = 1'b0;
          w_grant_n = '0;
          w_cnt_n   = '0;
        end else if (STEP_ACK_IN) begin
          w_state_n = S_ACK;
          w_dtack_n = 1'b1;
        end else begin
          w_state_n = S_STEP;
        end
      end
      S_ACK: begin
        if (!AS_IN) begin
          w_state_n = S_IDLE;
          w_dtack_n = 1'b0;
          w_req_n   = 1'b0;
          w_grant_n = '0;
          w_cnt_n   = '0;
        end else begin
          w_state_n = S_ACK;
        end
      end
      S_ERROR: begin
        if (!AS_IN) begin
          w_state_n = S_IDLE;
          w_berr_n  = 1'b0;
        end else begin
          w_berr_n  = 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_req_n   = 1'b0;
        w_dtack_n = 1'b0;
        w_berr_n  = 1'b0;
        w_grant_n = '0;
      end
    endcase
  end

  // State and output registers, falling-edge clocked, asynchronous abort on RUN_IN low
  always_ff @(negedge MCLK_IN or negedge RUN_IN) begin
    if (!RUN_IN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_dtack <= 1'b0;
      r_berr  <= 1'b0;
      r_grant <= '0;
      r_busy  <= 1'b0;
`ifdef BERR_TIMEOUT_EN
      r_tocnt <= 8'd0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_req   <= w_req_n;
      r_dtack <= w_dtack_n;
      r_berr  <= w_berr_n;
      r_grant <= w_grant_n;
      r_busy  <= (w_state_n != S_IDLE);
`ifdef BERR_TIMEOUT_EN
      r_tocnt <= w_tocnt_n;
`endif
    end
  end

  assign STEP_REQ = r_req;
  assign DTACK    = r_dtack;
  assign BERR     = r_berr;
  assign GRANT    = r_grant;
  assign BUSY     = r_busy;

endmodule

// File: tb/tb_dtack_wait_controller.sv
// Self-checking bench for dtack_wait_controller: directed scenarios with
// literal expectations plus a randomized run checked every falling edge
// against a transaction-level model of the bus cycle.
module tb_dtack_wait_controller;

  localparam int         NREQ = 4;
  localparam int         WB   = 4;
  localparam logic [15:0] CFG = 16'h5130;   // waits: req0=0, req1=3, req2=1, req3=5
  localparam logic [7:0]  TMO = 8'd16;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       as_in  = 1'b0;
  logic       ack_in = 1'b0;
  logic [3:0] cs_in  = 4'd0;
  logic       step_req, dtack, berr, busy;
  logic [3:0] grant;

  dtack_wait_controller #(.NREQ(NREQ), .WAIT_BITS(WB), .WAIT_CFG(CFG), .TIMEOUT(TMO)) dut (
    .MCLK_IN(clk), .RUN_IN(rst_n), .AS_IN(as_in), .CS_IN(cs_in), .STEP_ACK_IN(ack_in),
    .STEP_REQ(step_req), .DTACK(dtack), .BERR(berr), .GRANT(grant), .BUSY(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cfg_tbl [4] = '{0, 3, 1, 5};

  bit   free_run = 1'b1;
  logic ack_m    = 1'b0;
  logic stp_q    = 1'b0;

  // Transaction-level model: is a cycle in flight, who owns it, how many
  // wait edges remain, has the stepper been asked / has it answered.
  bit         m_active, m_req, m_dtack, m_berr;
  logic [3:0] m_grant;
  int         m_wait, m_uncnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_req = 0; m_dtack = 0; m_berr = 0; m_grant = 4'd0; m_wait = 0; m_uncnt = 0;
  endtask

  task automatic model_step(input logic as, input logic [3:0] cs, input logic ack);
    logic [3:0] lsb;
    int idx;
    if (m_berr) begin
      if (!as) m_berr = 0;
    end else if (!m_active) begin
      if (as && cs != 4'd0) begin
        lsb = cs & (~cs + 4'd1);
        idx = 0;
        for (int i = 0; i < 4; i++) if (lsb[i]) idx = i;
        m_grant  = lsb;
        m_wait   = cfg_tbl[idx];
        m_active = 1;
        m_req    = (m_wait == 0);
        m_dtack  = 0;
        m_uncnt  = 0;
      end else if (as) begin
`ifdef BERR_TIMEOUT_EN
        m_uncnt++;
        if (m_uncnt == int'(TMO)) begin
          m_berr  = 1;
          m_uncnt = 0;
        end
`endif
      end else begin
        m_uncnt = 0;
      end
    end else if (!as) begin
      m_active = 0; m_req = 0; m_dtack = 0; m_grant = 4'd0;
    end else if (m_dtack) begin
      m_dtack = 1;
    end else if (m_req) begin
      if (ack) m_dtack = 1;
    end else begin
      m_wait--;
      if (m_wait == 0) m_req = 1;
    end
  endtask

  // Model update on each active edge, then compare once outputs have settled
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_step(as_in, cs_in, ack_in);
    #2;
    if (rst_n) begin
      check("model_step_req", step_req, m_req);
      check("model_dtack",    dtack,    m_dtack);
      check("model_berr",     berr,     m_berr);
      check("model_grant",    grant,    m_active ? m_grant : 4'd0);
      check("model_busy",     busy,     m_active || m_berr);
    end
  end

  // One bus-clock step: drive inputs on the rising edge, settle after the falling edge
  task automatic tick(input logic as, input logic [3:0] cs);
    @(posedge clk);
    as_in  = as;
    cs_in  = cs;
    ack_in = free_run ? stp_q : ack_m;
    stp_q  = step_req;
    @(negedge clk);
    #3;
  endtask

  initial begin
    int bad;
    logic       as_r;
    logic [3:0] cs_r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {step_req, dtack, berr, busy, grant}, 8'h00);
    rst_n = 1'b1;
    tick(1'b0, 4'd0);
    check("idle_after_reset", {step_req, dtack, berr, busy, grant}, 8'h00);

    // Zero-wait cycle, free-running stepper
    free_run = 1'b1;
    tick(1'b1, 4'b0001);
    check("zw_e0_req",   step_req, 1'b1);
    check("zw_e0_grant", grant,    4'b0001);
    check("zw_e0_dtack", dtack,    1'b0);
    tick(1'b1, 4'b0001);
    check("zw_e1_dtack", dtack, 1'b0);
    tick(1'b1, 4'b0001);
    check("zw_e2_dtack", dtack, 1'b1);
    check("zw_e2_grant", grant, 4'b0001);
    tick(1'b0, 4'd0);
    check("zw_clear", {step_req, dtack, berr, busy, grant}, 8'h00);

    // Wait states and priority: CS=0110 -> requester 1, three waits
    for (int e = 0; e < 6; e++) begin
      tick(1'b1, 4'b0110);
      check("wp_grant", grant,    4'b0010);
      check("wp_req",   step_req, (e >= 3) ? 1'b1 : 1'b0);
      check("wp_dtack", dtack,    (e >= 5) ? 1'b1 : 1'b0);
    end
    tick(1'b0, 4'd0);
    check("wp_clear", {step_req, dtack, berr, busy, grant}, 8'h00);

    // Stepper pause for 1000 edges
    free_run = 1'b0;
    ack_m    = 1'b0;
    tick(1'b1, 4'b0001);
    bad = 0;
    repeat (1000) begin
      tick(1'b1, 4'b0001);
      if (dtack !== 1'b0 || berr !== 1'b0 || step_req !== 1'b1) bad++;
    end
    check("pause_bad_edges", bad, 0);
    ack_m = 1'b1;
    tick(1'b1, 4'b0001);
    check("pause_release_dtack", dtack, 1'b1);
    ack_m = 1'b0;
    tick(1'b0, 4'd0);
    check("pause_clear", {step_req, dtack, berr, busy, grant}, 8'h00);

    // Abort in WAIT with two waits left
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b0010);
    check("abw_busy", busy, 1'b1);
    tick(1'b0, 4'b0010);
    check("abw_clear", {step_req, dtack, berr, busy, grant}, 8'h00);
    tick(1'b0, 4'd0);
    check("abw_no_dtack", dtack, 1'b0);

    // Abort in STEP coincident with acknowledge
    tick(1'b1, 4'b0001);
    check("abs_req", step_req, 1'b1);
    ack_m = 1'b1;
    tick(1'b0, 4'b0001);
    check("abs_clear", {step_req, dtack, berr, busy, grant}, 8'h00);
    ack_m = 1'b0;
    tick(1'b0, 4'd0);
    check("abs_no_dtack", dtack, 1'b0);

    // Reset asserted mid-STEP
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0100);
    check("rst_pre_req", step_req, 1'b1);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", {step_req, dtack, berr, busy, grant}, 8'h00);
    @(posedge clk);
    as_in = 1'b0;
    rst_n = 1'b1;
    tick(1'b0, 4'd0);
    check("rst_idle_busy", busy, 1'b0);

    // Unmapped strobe
    for (int e = 0; e < 20; e++) begin
      tick(1'b1, 4'd0);
`ifdef BERR_TIMEOUT_EN
      check("unmapped_berr", berr, (e >= 15) ? 1'b1 : 1'b0);
      check("unmapped_busy", busy, (e >= 15) ? 1'b1 : 1'b0);
`else
      check("unmapped_berr", berr, 1'b0);
      check("unmapped_busy", busy, 1'b0);
`endif
    end
    tick(1'b0, 4'd0);
    check("unmapped_clear", {berr, busy}, 2'b00);

    // Randomized traffic against the model
    as_r = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) free_run = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) as_r = ~as_r;
      cs_r  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ack_m = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk);
        rst_n = 1'b0;
        as_in = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        as_r  = 1'b0;
      end
      tick(as_r, cs_r);
    end

    tick(1'b0, 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
